// File: rtl/ps2_move_encoder_pkg.sv
// ps2_move_encoder_pkg: direction codes, scan codes and the key-to-direction map shared by the PS/2 move encoder.
package ps2_move_encoder_pkg;
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;

    localparam int FRAME_LEN = 11;

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} scan_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] dir;
    } map_t;

    // WASD only maps outside an E0 prefix, arrows only inside one.
    function automatic map_t map_code(input logic [7:0] code, input logic ext);
        map_t m;
        m = '{hit: 1'b1, dir: DIR_UP};
        case ({ext, code})
            {1'b0, SC_W}, {1'b1, SC_UP}:    m.dir = DIR_UP;
            {1'b0, SC_D}, {1'b1, SC_RIGHT}: m.dir = DIR_RIGHT;
            {1'b0, SC_S}, {1'b1, SC_DOWN}:  m.dir = DIR_DOWN;
            {1'b0, SC_A}, {1'b1, SC_LEFT}:  m.dir = DIR_LEFT;
            default:                        m.hit = 1'b0;
        endcase
        return m;
    endfunction
endpackage

// File: rtl/ps2_move_encoder_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver with synchronisers, parity/stop check and a mid-frame watchdog.
module ps2_rx_frame
    import ps2_move_encoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       byte_valid,
    output logic       frame_error
);
    localparam int         WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] LAST  = 4'(FRAME_LEN - 1);

    logic [1:0]      clk_sync_q, dat_sync_q;
    logic            clk_prev_q;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [8:0]      shift_q, shift_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [7:0]      key_q, key_d;
    logic            bv_q, bv_d, fe_q, fe_d;
    logic            fall, bit_in;

    assign fall   = clk_prev_q & ~clk_sync_q[1];
    assign bit_in = dat_sync_q[1];

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wd_d      = wd_q;
        key_d     = key_q;
        bv_d      = 1'b0;
        fe_d      = 1'b0;
        if (fall) begin
            wd_d = '0;
            if (bit_cnt_q == 4'd0) begin
                fe_d      = bit_in;
                bit_cnt_d = bit_in ? 4'd0 : 4'd1;
            end else if (bit_cnt_q == LAST) begin
                bit_cnt_d = 4'd0;
                // shift_q holds D0..D7 in [7:0] and parity in [8]
                if (^shift_q && bit_in) begin
                    key_d = shift_q[7:0];
                    bv_d  = 1'b1;
                end else begin
                    fe_d = 1'b1;
                end
            end else begin
                shift_d   = {bit_in, shift_q[8:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wd_d      = '0;
                bit_cnt_d = 4'd0;
                fe_d      = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            wd_q       <= '0;
            key_q      <= '0;
            bv_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            clk_prev_q <= clk_sync_q[1];
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wd_q       <= wd_d;
            key_q      <= key_d;
            bv_q       <= bv_d;
            fe_q       <= fe_d;
        end
    end

    assign key_code    = key_q;
    assign byte_valid  = bv_q;
    assign frame_error = fe_q;
endmodule

// File: rtl/ps2_move_encoder.sv
// ps2_move_encoder: decodes PS/2 make/break/extended scan codes into a held 32-bit direction for the processor.
module ps2_move_encoder
    import ps2_move_encoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int RESET_MOVE     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] move,
    output logic        move_valid,
    output logic [7:0]  key_code,
    output logic        byte_valid,
    output logic        frame_error
);
    scan_state_e state_q, state_d;
    logic [1:0]  move_q, move_d;
    logic        mv_q, hit;
    map_t        m;

    ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_code   (key_code),
        .byte_valid (byte_valid),
        .frame_error(frame_error)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            move_q  <= 2'(RESET_MOVE);
            mv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            move_q  <= move_d;
            mv_q    <= hit;
        end
    end

    always_comb begin
        state_d = state_q;
        if (byte_valid) begin
            case (state_q)
                ST_IDLE: state_d = key_code == SC_E0 ? ST_EXT : key_code == SC_F0 ? ST_BRK : ST_IDLE;
                ST_EXT:  state_d = key_code == SC_F0 ? ST_EXT_BRK : key_code == SC_E0 ? ST_EXT : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Break codes fall through BRK/EXT_BRK without ever reaching the map.
    always_comb begin
        m      = map_code(key_code, state_q == ST_EXT);
        hit    = byte_valid && m.hit && key_code != SC_E0 && key_code != SC_F0
                 && (state_q == ST_IDLE || state_q == ST_EXT);
        move_d = hit ? m.dir : move_q;
    end

    assign move       = {30'b0, move_q};
    assign move_valid = mv_q;
endmodule
